seq_divider: RTL and testbench

//  Iterative RV32M divide unit (DIV/DIVU/REM/REMU) for the sail-core ALU path.

---
 rtl/seq_divider_pkg.sv | 30 +++
 rtl/div_sign_fix.sv | 15 +
 rtl/seq_divider.sv | 158 +++++++++++++++
 tb/tb_seq_divider.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// Shared constants, operation and state encodings for the iterative divider.
package seq_divider_pkg;

  localparam int DIV_WIDTH = 32;

  // RV32M divide-family operation codes: bit1 selects remainder, bit0 selects unsigned.
  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_ITER = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } div_state_e;

  function automatic logic op_is_signed(input logic [1:0] f_op);
    return ~f_op[0];
  endfunction

  function automatic logic op_is_rem(input logic [1:0] f_op);
    return f_op[1];
  endfunction

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negate; used for absolute values and final sign fix-up.
module div_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_val,
  input  logic             i_neg,
  output logic [WIDTH-1:0] o_val
);

  logic [WIDTH-1:0] w_neg_val;

  assign w_neg_val = ~i_val + {{(WIDTH-1){1'b0}}, 1'b1};
  assign o_val     = i_neg ? w_neg_val : i_val;

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle,
// using an external subtractor through sub_in1/sub_in2/sub_out/sub_carry.
//
// Handshake: start is sampled only while idle (busy=0); an accepted start raises
// busy from the next cycle until the done cycle inclusive. done is a one-cycle
// pulse and result is valid from that cycle, held until a later result replaces it.
// start seen while busy is dropped, never queued.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH     = DIV_WIDTH,
  parameter bit FAST_SPEC = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] sub_in1,
  output logic [WIDTH-1:0] sub_in2,
  input  logic [WIDTH-1:0] sub_out,
  input  logic             sub_carry,
  output logic [2:0]       dbg_state
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e       r_state, w_next;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_a, r_b, r_rem, r_quo, r_result;
  logic [CNT_W-1:0] r_cnt;
  logic             r_q_neg, r_r_neg;

  logic             w_signed, w_in_zero, w_in_ovf, w_fast, w_accept;
  logic [WIDTH-1:0] w_fast_result, w_trial;
  logic [WIDTH-1:0] w_fix0_in, w_fix1_in, w_fix0_out, w_fix1_out;
  logic             w_fix0_neg, w_fix1_neg;

  assign w_signed = op_is_signed(r_op);

  // Special cases are decided on the live inputs while idle so they can skip iteration.
  assign w_in_zero = (divisor == '0);
  assign w_in_ovf  = op_is_signed(op) && (dividend == MIN_NEG) && (divisor == '1);
  assign w_fast    = FAST_SPEC && (w_in_zero || w_in_ovf);
  assign w_fast_result = w_in_zero ? (op_is_rem(op) ? dividend : '1)
                                   : (op_is_rem(op) ? '0 : MIN_NEG);

  // Restoring step: a set rem MSB means the shifted trial exceeds any divisor.
  assign w_trial  = {r_rem[WIDTH-2:0], r_quo[WIDTH-1]};
  assign w_accept = r_rem[WIDTH-1] | sub_carry;

  assign sub_in1 = (r_state == ST_ITER) ? w_trial : '0;
  assign sub_in2 = (r_state == ST_ITER) ? r_b     : '0;

  // One negator pair is shared: absolute values in PREP, sign fix-up in FIX.
  always_comb begin
    w_fix0_in  = r_a;
    w_fix1_in  = r_b;
    w_fix0_neg = 1'b0;
    w_fix1_neg = 1'b0;
    if (r_state == ST_PREP) begin
      w_fix0_neg = w_signed & r_a[WIDTH-1];
      w_fix1_neg = w_signed & r_b[WIDTH-1];
    end else if (r_state == ST_FIX) begin
      w_fix0_in  = r_quo;
      w_fix1_in  = r_rem;
      w_fix0_neg = r_q_neg;
      w_fix1_neg = r_r_neg;
    end
  end

  div_sign_fix #(.WIDTH(WIDTH)) u_fix0 (
    .i_val (w_fix0_in),
    .i_neg (w_fix0_neg),
    .o_val (w_fix0_out)
  );

  div_sign_fix #(.WIDTH(WIDTH)) u_fix1 (
    .i_val (w_fix1_in),
    .i_neg (w_fix1_neg),
    .o_val (w_fix1_out)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic: PREP, 32 ITER cycles, FIX, then a single DONE cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (start) w_next = w_fast ? ST_DONE : ST_PREP;
      ST_PREP: w_next = ST_ITER;
      ST_ITER: if (r_cnt == '0) w_next = ST_FIX;
      ST_FIX:  w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Datapath: capture, absolute values, shift/subtract iteration and result fix-up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_cnt    <= '0;
      r_q_neg  <= 1'b0;
      r_r_neg  <= 1'b0;
      r_result <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_op <= op;
            r_a  <= dividend;
            r_b  <= divisor;
            if (w_fast) r_result <= w_fast_result;
          end
        end
        ST_PREP: begin
          r_quo   <= w_fix0_out;
          r_b     <= w_fix1_out;
          r_rem   <= '0;
          r_cnt   <= CNT_W'(WIDTH - 1);
          // A zero divisor must leave the all-ones quotient un-negated.
          r_q_neg <= w_signed & (r_a[WIDTH-1] ^ r_b[WIDTH-1]) & (r_b != '0);
          r_r_neg <= w_signed & r_a[WIDTH-1];
        end
        ST_ITER: begin
          r_quo <= {r_quo[WIDTH-2:0], w_accept};
          r_rem <= w_accept ? sub_out : w_trial;
          r_cnt <= r_cnt - CNT_W'(1);
        end
        ST_FIX: begin
          r_result <= op_is_rem(r_op) ? w_fix1_out : w_fix0_out;
        end
        default: begin
        end
      endcase
    end
  end

  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);
  assign result    = r_result;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed RV32M cases plus randomized operands
// against an arithmetic reference model, with the parent subtractor modelled here.
module tb_seq_divider;
  import seq_divider_pkg::*;

  logic        clk, rst, start;
  logic [1:0]  op;
  logic [31:0] dividend, divisor, result, sub_in1, sub_in2, sub_out;
  logic        busy, done, sub_carry;
  logic [2:0]  dbg_state;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  seq_divider #(.WIDTH(32), .FAST_SPEC(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .sub_in1   (sub_in1),
    .sub_in2   (sub_in2),
    .sub_out   (sub_out),
    .sub_carry (sub_carry),
    .dbg_state (dbg_state)
  );

  // Upstream subtractor owned by the parent ALU.
  assign sub_out   = sub_in1 - sub_in2;
  assign sub_carry = (sub_in1 >= sub_in2);

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: RV32M results from plain arithmetic.
  function automatic bit ref_special(input logic [1:0] f_op, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (!f_op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] ref_result(input logic [1:0] f_op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!f_op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else if (!f_op[0]) begin
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
    return f_op[1] ? r : q;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Driver: issue one operation, optionally poke start mid-op or hold it through DONE.
  task automatic do_op(input logic [1:0] f_op, input logic [31:0] a, input logic [31:0] b,
                       input int poke_at, input bit hold_done);
    int          exp_lat;
    int          lat;
    bit          busy_ok;
    logic [31:0] exp_v;
    exp_q.push_back(ref_result(f_op, a, b));
    exp_lat = ref_special(f_op, a, b) ? 1 : 35;
    op = f_op; dividend = a; divisor = b; start = 1'b1;
    lat = 0;
    busy_ok = 1'b1;
    for (int k = 1; k <= 60 && lat == 0; k++) begin
      @(posedge clk); #1;
      start    = (k == poke_at);
      dividend = $urandom;
      divisor  = $urandom;
      if (k == poke_at) op = 2'($urandom_range(0, 3));
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (done === 1'b1) lat = k;
    end
    check("latency", lat, exp_lat);
    check1("busy_during_op", busy_ok, 1'b1);
    exp_v = exp_q.pop_front();
    check("result", result, exp_v);
    start = hold_done;
    @(posedge clk); #1;
    start = 1'b0;
    check1("busy_after_done", busy, 1'b0);
    check1("done_one_cycle", done, 1'b0);
    check("result_held", result, exp_v);
    check("sub_in_idle", sub_in1 | sub_in2, 32'd0);
    if (hold_done) begin
      @(posedge clk); #1;
      check1("start_in_done_ignored", busy, 1'b0);
    end
  endtask

  // Directed then randomized stimulus.
  initial begin
    logic [31:0] a, b;
    logic [1:0]  f_op;
    bit          saw_done;
    rst = 1'b1; start = 1'b0; op = 2'b00; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    check1("reset_busy", busy, 1'b0);
    check1("reset_done", done, 1'b0);
    check("reset_result", result, 32'd0);
    check("reset_sub_in1", sub_in1, 32'd0);
    check("reset_sub_in2", sub_in2, 32'd0);
    check("reset_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0;
    @(posedge clk); #1;

    do_op(OP_DIVU, 32'd100, 32'd7, 0, 1'b0);
    check("divu_100_7", result, 32'd14);
    do_op(OP_REMU, 32'd100, 32'd7, 0, 1'b0);
    check("remu_100_7", result, 32'd2);
    do_op(OP_DIV, 32'hFFFF_FFEC, 32'd3, 0, 1'b0);
    check("div_m20_3", result, 32'hFFFF_FFFA);
    do_op(OP_REM, 32'hFFFF_FFEC, 32'd3, 0, 1'b0);
    check("rem_m20_3", result, 32'hFFFF_FFFE);
    do_op(OP_DIVU, 32'hFFFF_FFFF, 32'd1, 0, 1'b0);
    check("divu_max_1", result, 32'hFFFF_FFFF);
    do_op(OP_REMU, 32'hFFFF_FFFF, 32'h8000_0000, 0, 1'b0);
    check("remu_max_min", result, 32'h7FFF_FFFF);
    do_op(OP_DIV, 32'd5, 32'd0, 0, 1'b0);
    check("div_by_zero", result, 32'hFFFF_FFFF);
    do_op(OP_REM, 32'd5, 32'd0, 0, 1'b0);
    check("rem_by_zero", result, 32'd5);
    do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    check("div_overflow", result, 32'h8000_0000);
    do_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    check("rem_overflow", result, 32'd0);
    do_op(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    check("divu_min_max", result, 32'd0);

    // start pulse mid-operation and start held during DONE are both ignored.
    do_op(OP_DIV, 32'd1000, 32'hFFFF_FFF9, 10, 1'b0);
    check("poke_ignored", result, 32'hFFFF_FF72);
    do_op(OP_REMU, 32'd12345, 32'd100, 0, 1'b1);
    check("hold_in_done", result, 32'd45);

    // Asynchronous reset during an operation.
    op = OP_DIVU; dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    rst = 1'b1;
    #1;
    check1("abort_busy", busy, 1'b0);
    check1("abort_done", done, 1'b0);
    check("abort_result", result, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1) saw_done = 1'b1;
    end
    check1("abort_no_done", saw_done, 1'b0);
    do_op(OP_DIVU, 32'd1000, 32'd3, 0, 1'b0);
    check("after_abort", result, 32'd333);

    // Randomized operands against the reference model.
    for (int i = 0; i < 30; i++) begin
      f_op = 2'($urandom_range(0, 3));
      a = $urandom;
      case ($urandom_range(0, 9))
        0:       b = 32'd0;
        1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2:       b = $urandom_range(1, 15);
        3:       b = 32'hFFFF_FFFF - $urandom_range(0, 7);
        4:       b = $urandom >> $urandom_range(1, 31);
        default: b = $urandom;
      endcase
      do_op(f_op, a, b, 0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
